// File: rtl/edge_ai_soc_lite_pkg.sv
// Shared constants and state encodings for the edge-AI SoC shell.
package edge_ai_soc_lite_pkg;
  localparam int          CLKS_PER_BIT_DEF = 868;
  localparam logic        UART_IDLE        = 1'b1;
  localparam logic [31:0] GPIO_RESET       = 32'h0;
  localparam logic [23:0] GPIO_UPPER       = 24'h0;
  localparam logic        SPI_CLK_IDLE     = 1'b0;
  localparam logic        SPI_MOSI_IDLE    = 1'b0;
  localparam logic        SPI_CS_IDLE      = 1'b1;
  localparam logic        SPI_DC_IDLE      = 1'b0;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {SEQ_WAIT, SEQ_POP, SEQ_WRITE} seq_state_t;
endpackage

// File: rtl/edge_uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer plus start/data/stop FSM.
import edge_ai_soc_lite_pkg::*;

module edge_uart_rx #(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data
);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  logic [1:0]    sync;
  logic          rx_s, rx_prev;
  rx_state_t     state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;

  assign rx_s = sync[1];

  // Synchronizer resets to the idle level so release never looks like a start edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync    <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      sync    <= {sync[0], rx};
      rx_prev <= rx_s;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= RX_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      case (state)
        RX_IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
          if (rx_prev && !rx_s) state <= RX_START;
        end
        RX_START: begin
          if (cnt == HALF) begin
            cnt   <= '0;
            state <= rx_s ? RX_IDLE : RX_DATA;
          end else cnt <= cnt + 1'b1;
        end
        RX_DATA: begin
          if (cnt == LAST) begin
            cnt     <= '0;
            shift   <= {rx_s, shift[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) state <= RX_STOP;
          end else cnt <= cnt + 1'b1;
        end
        RX_STOP: begin
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= RX_IDLE;
          end else cnt <= cnt + 1'b1;
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

  // Strobe decoded on the stop-sample cycle so the FIFO captures on that same edge.
  assign byte_valid = (state == RX_STOP) && (cnt == LAST) && rx_s;
  assign byte_data  = shift;
endmodule

// File: rtl/edge_ai_soc_lite.sv
// Edge-AI SoC shell: UART RX -> FIFO -> boot sequencer -> GPIO, UART TX, idle tie-offs.
// Optional build macro UART_ECHO_EN: sequencer also echoes each byte on UART TX.
import edge_ai_soc_lite_pkg::*;

module edge_ai_soc_lite #(
  parameter int CLKS_PER_BIT  = CLKS_PER_BIT_DEF,
  parameter int RX_FIFO_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_uart_rx,
  output logic        io_uart_tx,
  input  logic [31:0] io_gpio_in,
  output logic [31:0] io_gpio_out,
  output logic        io_lcd_spi_clk,
  output logic        io_lcd_spi_mosi,
  output logic        io_lcd_spi_cs,
  output logic        io_lcd_spi_dc,
  output logic        io_lcd_spi_rst,
  output logic        io_lcd_backlight,
  output logic        io_trap,
  output logic        io_compact_irq,
  output logic        io_bitnet_irq,
  output logic        io_uart_tx_irq,
  output logic        io_uart_rx_irq
);
  localparam int AW = $clog2(RX_FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [31:0] gpio_q1, gpio_q2;
  logic        unused_gpio;
  logic        lcd_on;

  always_ff @(posedge clock) begin
    if (reset) begin
      gpio_q1 <= '0;
      gpio_q2 <= '0;
      lcd_on  <= 1'b0;
    end else begin
      gpio_q1 <= io_gpio_in;
      gpio_q2 <= gpio_q1;
      lcd_on  <= 1'b1;
    end
  end

  assign unused_gpio      = ^gpio_q2;
  assign io_lcd_spi_clk   = SPI_CLK_IDLE;
  assign io_lcd_spi_mosi  = SPI_MOSI_IDLE;
  assign io_lcd_spi_cs    = SPI_CS_IDLE;
  assign io_lcd_spi_dc    = SPI_DC_IDLE;
  assign io_lcd_spi_rst   = lcd_on;
  assign io_lcd_backlight = lcd_on;
  assign io_trap          = 1'b0;
  assign io_compact_irq   = 1'b0;
  assign io_bitnet_irq    = 1'b0;

  logic       rx_valid;
  logic [7:0] rx_data;

  edge_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clock      (clock),
    .reset      (reset),
    .rx         (io_uart_rx),
    .byte_valid (rx_valid),
    .byte_data  (rx_data)
  );

  logic [7:0]    fifo_mem [RX_FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, empty, push, pop;
  seq_state_t    seq_state;
  logic [7:0]    seq_byte;

  assign full  = (count == (AW+1)'(RX_FIFO_DEPTH));
  assign empty = (count == '0);
  assign push  = rx_valid && !full;
  assign pop   = (seq_state == SEQ_POP);

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < RX_FIFO_DEPTH; i++) fifo_mem[i] <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= rx_data;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign io_uart_rx_irq = !empty;

  logic       tx_busy, tx_line, tx_irq, tx_ready, tx_start;
  logic [CW-1:0] tx_cnt;
  logic [3:0] tx_idx;
  logic [8:0] tx_shift;

`ifdef UART_ECHO_EN
  assign tx_ready = !tx_busy;
  assign tx_start = (seq_state == SEQ_WRITE);
`else
  assign tx_ready = 1'b1;
  assign tx_start = 1'b0;
`endif

  // Sequencer only leaves WAIT when TX is free, so WRITE always finds TX idle.
  always_ff @(posedge clock) begin
    if (reset) begin
      seq_state   <= SEQ_WAIT;
      seq_byte    <= '0;
      io_gpio_out <= GPIO_RESET;
    end else begin
      case (seq_state)
        SEQ_WAIT:  if (!empty && tx_ready) seq_state <= SEQ_POP;
        SEQ_POP: begin
          seq_byte  <= fifo_mem[rd_ptr];
          seq_state <= SEQ_WRITE;
        end
        SEQ_WRITE: begin
          io_gpio_out <= {GPIO_UPPER, seq_byte};
          seq_state   <= SEQ_WAIT;
        end
        default:   seq_state <= SEQ_WAIT;
      endcase
    end
  end

  // tx_shift holds the remaining data bits plus the stop bit; start bit goes out on accept.
  always_ff @(posedge clock) begin
    if (reset) begin
      tx_busy  <= 1'b0;
      tx_line  <= UART_IDLE;
      tx_irq   <= 1'b0;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
    end else begin
      tx_irq <= 1'b0;
      if (!tx_busy) begin
        if (tx_start) begin
          tx_busy  <= 1'b1;
          tx_line  <= 1'b0;
          tx_shift <= {1'b1, seq_byte};
          tx_cnt   <= '0;
          tx_idx   <= '0;
        end
      end else if (tx_cnt == LAST) begin
        tx_cnt <= '0;
        if (tx_idx == 4'd9) begin
          tx_busy <= 1'b0;
          tx_line <= UART_IDLE;
          tx_irq  <= 1'b1;
        end else begin
          tx_line  <= tx_shift[0];
          tx_shift <= {1'b0, tx_shift[8:1]};
          tx_idx   <= tx_idx + 1'b1;
        end
      end else tx_cnt <= tx_cnt + 1'b1;
    end
  end

  assign io_uart_tx     = tx_line;
  assign io_uart_tx_irq = tx_irq;
endmodule

// File: tb/tb_edge_ai_soc_lite.sv
// Scoreboard bench for edge_ai_soc_lite; shortened bit period keeps the run small.
import edge_ai_soc_lite_pkg::*;

module tb_edge_ai_soc_lite;
  localparam int CPB = 64;

  logic        clock = 1'b0, reset = 1'b1, uart_rx = 1'b1;
  logic [31:0] gpio_in = 32'hDEAD_BEEF;
  logic [31:0] gpio_out;
  logic uart_tx, spi_clk, spi_mosi, spi_cs, spi_dc, spi_rst, backlight;
  logic trap, compact_irq, bitnet_irq, tx_irq, rx_irq;

  edge_ai_soc_lite #(.CLKS_PER_BIT(CPB), .RX_FIFO_DEPTH(4)) dut (
    .clock(clock), .reset(reset), .io_uart_rx(uart_rx), .io_uart_tx(uart_tx),
    .io_gpio_in(gpio_in), .io_gpio_out(gpio_out),
    .io_lcd_spi_clk(spi_clk), .io_lcd_spi_mosi(spi_mosi), .io_lcd_spi_cs(spi_cs),
    .io_lcd_spi_dc(spi_dc), .io_lcd_spi_rst(spi_rst), .io_lcd_backlight(backlight),
    .io_trap(trap), .io_compact_irq(compact_irq), .io_bitnet_irq(bitnet_irq),
    .io_uart_tx_irq(tx_irq), .io_uart_rx_irq(rx_irq)
  );

  always #5 clock = ~clock;

  int errors = 0, checks = 0;
  int tx_irqs = 0, tx_lows = 0, n_tx = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  tx_q[$];
  logic [31:0] last_gpio = 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // GPIO scoreboard: every visible change on the pin must be the next expected byte.
  always @(negedge clock) begin
    if (reset) last_gpio = 32'h0;
    else if (gpio_out !== last_gpio) begin
      if (exp_q.size() == 0) chk("gpio_unexpected", gpio_out, last_gpio);
      else chk("gpio_byte", gpio_out, {24'h0, exp_q.pop_front()});
      last_gpio = gpio_out;
    end
    if (tx_irq) tx_irqs++;
    if (uart_tx !== 1'b1) tx_lows++;
  end

`ifdef UART_ECHO_EN
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge uart_tx);
      if (!reset) begin
        repeat (CPB/2) @(posedge clock);
        #1 chk("tx_start_bit", uart_tx, 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(posedge clock);
          #1 b[i] = uart_tx;
        end
        repeat (CPB) @(posedge clock);
        #1 chk("tx_stop_bit", uart_tx, 1'b1);
        if (tx_q.size() == 0) chk("tx_unexpected", 0, 1);
        else chk("tx_byte", b, tx_q.pop_front());
      end
    end
  end
`endif

  task automatic send_byte(input logic [7:0] d, input logic stop);
    if (stop) begin
      exp_q.push_back(d);
`ifdef UART_ECHO_EN
      tx_q.push_back(d);
      n_tx++;
`endif
    end
    @(negedge clock);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      uart_rx = d[i];
      repeat (CPB) @(negedge clock);
    end
    uart_rx = stop;
    repeat (CPB) @(negedge clock);
    uart_rx = 1'b1;
    repeat (CPB) @(negedge clock);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 4*CPB && exp_q.size() != 0; i++) @(negedge clock);
    chk(tag, exp_q.size(), 0);
  endtask

  task automatic tx_drain();
`ifdef UART_ECHO_EN
    for (int i = 0; i < 14*CPB && tx_q.size() != 0; i++) @(negedge clock);
    chk("tx_drain", tx_q.size(), 0);
    repeat (4) @(negedge clock);
    chk("tx_irq_count", tx_irqs, n_tx);
`endif
  endtask

  initial begin
    logic [7:0] pat [4] = '{8'h55, 8'hAA, 8'h33, 8'hCC};

    repeat (2) @(negedge clock);
    chk("rst_lcd_rst", spi_rst, 1'b0);
    chk("rst_backlight", backlight, 1'b0);
    chk("rst_uart_tx", uart_tx, 1'b1);
    chk("rst_gpio", gpio_out, 32'h0);
    reset = 1'b0;
    @(negedge clock);
    chk("idle_uart_tx", uart_tx, 1'b1);
    chk("idle_gpio", gpio_out, 32'h0);
    chk("idle_cs", spi_cs, 1'b1);
    chk("idle_lcd_rst", spi_rst, 1'b1);
    chk("idle_backlight", backlight, 1'b1);
    chk("idle_spi_misc", {spi_clk, spi_mosi, spi_dc}, 3'b000);
    chk("idle_irqs", {trap, compact_irq, bitnet_irq, tx_irq, rx_irq}, 5'b0);
    repeat (CPB) @(negedge clock);

    foreach (pat[i]) send_byte(pat[i], 1'b1);
    drain("pattern_drain");
    tx_drain();

    uart_rx = 1'b0;
    repeat (20) @(negedge clock);
    uart_rx = 1'b1;
    repeat (3*CPB) @(negedge clock);
    chk("glitch_rx_irq", rx_irq, 1'b0);
    chk("glitch_gpio", gpio_out, 32'hCC);

    send_byte(8'h5A, 1'b0);
    repeat (CPB) @(negedge clock);
    chk("frame_err_rx_irq", rx_irq, 1'b0);
    chk("frame_err_gpio", gpio_out, 32'hCC);
    send_byte(8'h3C, 1'b1);
    drain("after_frame_err");
    tx_drain();

    send_byte(8'hA5, 1'b1);
    drain("echo_byte");
    tx_drain();
    repeat (12*CPB) @(negedge clock);

    uart_rx = 1'b0;
    repeat (CPB) @(negedge clock);
    uart_rx = 1'b1;
    repeat (CPB) @(negedge clock);
    uart_rx = 1'b0;
    repeat (CPB/2) @(negedge clock);
    uart_rx = 1'b1;
    reset   = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("midreset_gpio", gpio_out, 32'h0);
    chk("midreset_rx_irq", rx_irq, 1'b0);
    repeat (CPB) @(negedge clock);
    send_byte(8'h11, 1'b1);
    drain("post_reset_byte");
    tx_drain();
    chk("gpio_upper_zero", gpio_out[31:8], 24'h0);

`ifndef UART_ECHO_EN
    chk("no_echo_tx_low", tx_lows, 0);
    chk("no_echo_tx_irq", tx_irqs, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
